// File: rtl/mem_rd_streamer_if.sv
// Bundles the start/status, memory read port and output stream signals of mem_rd_streamer.
// The master modport is the streamer's view; slave is the surrounding system / memory side.
interface mem_rd_streamer_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 16,
    parameter int unsigned LW = 16
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;

    logic          wr_active;
    logic          ren;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] mem_dout;

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (
        input  start, base_addr, len, wr_active, mem_dout, m_ready,
        output busy, done, ren, rd_ptr, m_valid, m_data
    );

    modport slave (
        output start, base_addr, len, wr_active, mem_dout, m_ready,
        input  busy, done, ren, rd_ptr, m_valid, m_data
    );
endinterface

// File: rtl/mem_rd_streamer.sv
// Streams len consecutive words from a 1-cycle-latency memory into a first-word-fall-through FIFO,
// issuing reads only when the write port is idle and the FIFO has credit for the returning word.
module mem_rd_streamer #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 16,
    parameter int unsigned LW = 16,
    parameter int unsigned FD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_rd_streamer_if.master  bus
);
    localparam int unsigned PW = $clog2(FD);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic          zl_done;

    logic [DW-1:0] fifo_mem [FD];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic [CW-1:0] pending;
    logic          issue;
    logic          pop;
    logic          pop_store;
    logic          push;
    logic          last_pop;

    // Credit: stored words plus the word still on mem_dout must leave room for one more.
    assign fifo_empty = (count == '0);
    assign pending    = count + CW'(inflight);
    assign issue      = rst_n && (state == RUN) && !bus.wr_active
                        && (remaining != '0) && (pending < CW'(FD));

    // A word returning into an empty FIFO falls straight through to the output.
    assign bus.m_valid = !fifo_empty || inflight;
    assign bus.m_data  = fifo_empty ? bus.mem_dout : fifo_mem[rd_idx];
    assign pop         = bus.m_valid && bus.m_ready;
    assign pop_store   = pop && !fifo_empty;
    assign push        = inflight && !(pop && fifo_empty);
    assign last_pop    = (state == DRAIN) && pop && (pending == CW'(1));

    assign bus.ren    = issue;
    assign bus.rd_ptr = rd_ptr_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = rst_n && (zl_done || last_pop);

    // Control FSM, address/length counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr_q  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            zl_done   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            count     <= '0;
        end else begin
            inflight <= issue;
            zl_done  <= 1'b0;

            if (push)      wr_idx <= wr_idx + PW'(1);
            if (pop_store) rd_idx <= rd_idx + PW'(1);
            count <= count + CW'(push) - CW'(pop_store);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            state     <= RUN;
                            rd_ptr_q  <= bus.base_addr;
                            remaining <= bus.len;
                        end else begin
                            zl_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_ptr_q  <= rd_ptr_q + AW'(1);
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_idx] <= bus.mem_dout;
    end
endmodule

// File: tb/tb_mem_rd_streamer.sv
// Self-checking bench for mem_rd_streamer: an issued/popped-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized transfers with stalls and back-pressure.
module tb_mem_rd_streamer;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 16;
    localparam int unsigned FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_rd_streamer_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

    mem_rd_streamer #(.DW(DW), .AW(AW), .LW(LW), .FD(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] word_of(input logic [15:0] a);
        return {a, a ^ 16'h5AA5, ~a, a + 16'h0101};
    endfunction

    // Memory: data one cycle after ren, garbage otherwise.
    always @(posedge clk) begin
        if (bus.ren) bus.mem_dout <= word_of(bus.rd_ptr);
        else         bus.mem_dout <= {$urandom, $urandom};
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference model state: a transfer is described only by base, len, words issued and words popped.
    logic        act = 1'b0;
    logic        zl = 1'b0;
    logic [15:0] base_m = '0;
    int          len_m = 0;
    int          n_iss = 0;
    int          n_pop = 0;
    logic [15:0] rdp_m = '0;

    // Measurements of the DUT for the directed literal checks.
    logic [15:0] iss_q[$];
    int          pops = 0;
    int          first_valid = -1;
    int          done_cyc = -1;
    int          outst = 0;
    int          max_outst = 0;

    always @(negedge clk) begin
        int   avail;
        logic e_ren, e_valid, pop_e, e_done, zl_n;
        if (!rst_n) begin
            act = 1'b0; zl = 1'b0; n_iss = 0; n_pop = 0; rdp_m = '0;
        end else begin
            avail   = n_iss - n_pop;
            e_ren   = act && !bus.wr_active && (n_iss < len_m) && (avail < int'(FD));
            e_valid = act && (avail > 0);
            pop_e   = e_valid && bus.m_ready;
            e_done  = zl || (pop_e && (n_pop + 1 == len_m));

            chk("ren", 64'(bus.ren), 64'(e_ren));
            chk("rd_ptr", 64'(bus.rd_ptr), 64'(rdp_m));
            chk("m_valid", 64'(bus.m_valid), 64'(e_valid));
            if (e_valid) chk("m_data", bus.m_data, word_of(base_m + 16'(n_pop)));
            chk("busy", 64'(bus.busy), 64'(act));
            chk("done", 64'(bus.done), 64'(e_done));

            if (bus.ren) begin iss_q.push_back(bus.rd_ptr); outst++; end
            if (bus.m_valid && bus.m_ready) begin pops++; outst--; end
            if (outst > max_outst) max_outst = outst;
            if (bus.m_valid && first_valid < 0) first_valid = cyc;
            if (bus.done) done_cyc = cyc;

            zl_n = !act && bus.start && (bus.len == '0);
            if (act) begin
                if (e_ren) begin n_iss++; rdp_m = rdp_m + 16'd1; end
                if (pop_e) begin
                    n_pop++;
                    if (n_pop == len_m) act = 1'b0;
                end
            end else if (bus.start && bus.len != '0) begin
                act = 1'b1; base_m = bus.base_addr; len_m = int'(bus.len);
                n_iss = 0; n_pop = 0; rdp_m = bus.base_addr;
            end
            zl = zl_n;
        end
    end

    task automatic clear_meas();
        iss_q.delete();
        pops = 0; first_valid = -1; done_cyc = -1; outst = 0; max_outst = 0;
    endtask

    // Drives a one-cycle start; returns the start cycle number, leaves the caller in the following cycle.
    task automatic do_start(input logic [15:0] b, input logic [15:0] l, output int t);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = b; bus.len = l; t = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < 3000) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int n;
        logic [15:0] wexp [4];

        bus.start = 1'b0; bus.base_addr = '0; bus.len = '0;
        bus.wr_active = 1'b0; bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ren", 64'(bus.ren), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd_ptr", 64'(bus.rd_ptr), 64'd0);
        rst_n = 1'b1;

        // Basic transfer: issue T+1.., first word T+2, done with the 8th pop at T+9.
        clear_meas();
        do_start(16'h0010, 16'd8, t);
        wait_idle();
        chk("basic_first_valid", 64'(first_valid), 64'(t + 2));
        chk("basic_done_cyc", 64'(done_cyc), 64'(t + 9));
        chk("basic_pops", 64'(pops), 64'd8);
        chk("basic_issues", 64'(iss_q.size()), 64'd8);
        for (int i = 0; i < iss_q.size(); i++) chk("basic_addr", 64'(iss_q[i]), 64'(16'h0010 + 16'(i)));

        // Back-pressure: reads plus buffered words never exceed 4.
        clear_meas();
        bus.m_ready = 1'b0;
        do_start(16'h0800, 16'd16, t);
        repeat (9) @(posedge clk);
        #1 bus.m_ready = 1'b1;
        wait_idle();
        chk("bp_max_outstanding", 64'(max_outst), 64'd4);
        chk("bp_pops", 64'(pops), 64'd16);
        chk("bp_last_addr", 64'(iss_q[iss_q.size()-1]), 64'h080F);

        // Address wrap.
        clear_meas();
        wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000; wexp[3] = 16'h0001;
        do_start(16'hFFFE, 16'd4, t);
        wait_idle();
        chk("wrap_issues", 64'(iss_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < iss_q.size(); i++) chk("wrap_addr", 64'(iss_q[i]), 64'(wexp[i]));

        // Zero length: done one cycle after start, no read, busy low.
        clear_meas();
        do_start(16'h1234, 16'd0, t);
        chk("zl_done", 64'(bus.done), 64'd1);
        chk("zl_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        chk("zl_done_cyc", 64'(done_cyc), 64'(t + 1));
        chk("zl_issues", 64'(iss_q.size()), 64'd0);

        // Write contention on cycles T+3..T+6: 2 issues, stall, 8 more; done at T+15.
        clear_meas();
        do_start(16'h2000, 16'd10, t);
        @(posedge clk); #1;
        @(posedge clk); #1 bus.wr_active = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.wr_active = 1'b0;
        wait_idle();
        chk("wr_issues", 64'(iss_q.size()), 64'd10);
        chk("wr_pops", 64'(pops), 64'd10);
        chk("wr_done_cyc", 64'(done_cyc), 64'(t + 15));

        // Start while busy is ignored.
        clear_meas();
        do_start(16'h0300, 16'd6, t);
        bus.start = 1'b1; bus.base_addr = 16'h7777; bus.len = 16'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_idle();
        chk("ign_pops", 64'(pops), 64'd6);
        chk("ign_last_addr", 64'(iss_q[iss_q.size()-1]), 64'h0305);
        repeat (3) @(posedge clk);
        #1 chk("ign_stays_idle", 64'(bus.busy), 64'd0);

        // Reset mid-transfer after about 5 words, then a fresh transfer.
        clear_meas();
        do_start(16'h0100, 16'd20, t);
        n = 0;
        while (pops < 5 && n < 200) begin @(posedge clk); #1; n++; end
        chk("rst_mid_reached", 64'(pops >= 5), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstm_ren", 64'(bus.ren), 64'd0);
        chk("rstm_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rstm_busy", 64'(bus.busy), 64'd0);
        chk("rstm_done", 64'(bus.done), 64'd0);
        chk("rstm_rd_ptr", 64'(bus.rd_ptr), 64'd0);
        clear_meas();
        do_start(16'h4000, 16'd2, t);
        wait_idle();
        chk("rst_new_pops", 64'(pops), 64'd2);
        chk("rst_new_addr0", 64'(iss_q[0]), 64'h4000);

        // Randomized transfers with back-pressure, write stalls and ignored starts.
        for (int k = 0; k < 40; k++) begin
            int l;
            logic [15:0] b;
            b = 16'($urandom);
            l = $urandom_range(0, 24);
            clear_meas();
            bus.m_ready = 1'b1; bus.wr_active = 1'b0;
            do_start(b, 16'(l), t);
            n = 0;
            while (bus.busy && n < 3000) begin
                bus.m_ready   = ($urandom_range(0, 9) < 7);
                bus.wr_active = ($urandom_range(0, 4) == 0);
                bus.start     = ($urandom_range(0, 7) == 0);
                bus.base_addr = 16'($urandom);
                bus.len       = 16'($urandom_range(0, 5));
                @(posedge clk); #1;
                bus.start = 1'b0;
                n++;
            end
            bus.wr_active = 1'b0;
            chk("rand_timeout", 64'(bus.busy), 64'd0);
            @(posedge clk); #1;
            chk("rand_pops", 64'(pops), 64'(l));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
